// File: rtl/dap_pkg.sv
// Shared constants and FSM state type for the Double Accumulator Processor shift path.
package dap_pkg;

    localparam int WIDTH    = 16;
    localparam int AMT_W    = 4;
    localparam int BIG_STEP = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/shift_sequencer_if.sv
// Handshake and data bundle between the instruction control unit and the shift sequencer.
interface shift_sequencer_if;
    import dap_pkg::*;

    logic             start;
    logic [WIDTH-1:0] data_in;
    logic [AMT_W-1:0] amount;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    modport master (
        output start, data_in, amount,
        input  busy, done, result
    );

    modport slave (
        input  start, data_in, amount,
        output busy, done, result
    );

endinterface

// File: rtl/shift_sequencer_step.sv
// One combinational shift step: a 6-bit shift while at least BIG_STEP remains, otherwise a 1-bit shift.
module shifter_6bit
    import dap_pkg::*;
(
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);
    assign dout = {din[WIDTH-7:0], 6'b0};
endmodule

module shifter_1bit
    import dap_pkg::*;
(
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);
    assign dout = {din[WIDTH-2:0], 1'b0};
endmodule

module shift_step
    import dap_pkg::*;
(
    input  logic [WIDTH-1:0] work_in,
    input  logic [AMT_W-1:0] rem_in,
    output logic [WIDTH-1:0] work_out,
    output logic [AMT_W-1:0] rem_out
);
    localparam logic [AMT_W-1:0] BIG = AMT_W'(BIG_STEP);

    logic [WIDTH-1:0] big_out;
    logic [WIDTH-1:0] small_out;
    logic             sel_big;

    shifter_6bit u_big   (.din(work_in), .dout(big_out));
    shifter_1bit u_small (.din(work_in), .dout(small_out));

    assign sel_big  = (rem_in >= BIG);
    assign work_out = sel_big ? big_out : small_out;
    assign rem_out  = sel_big ? (rem_in - BIG) : (rem_in - AMT_W'(1));
endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle left-shift controller: composes a 0..15 bit shift from 6-bit and 1-bit steps.
module shift_sequencer
    import dap_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    shift_sequencer_if.slave   bus
);
    state_t           state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [AMT_W-1:0] rem_q, rem_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] step_work;
    logic [AMT_W-1:0] step_rem;

    shift_step u_step (
        .work_in  (work_q),
        .rem_in   (rem_q),
        .work_out (step_work),
        .rem_out  (step_rem)
    );

    always_comb begin
        state_d  = state_q;
        work_d   = work_q;
        rem_d    = rem_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    work_d = bus.data_in;
                    rem_d  = bus.amount;
                    // A zero shift skips SHIFT entirely, so result is loaded here.
                    if (bus.amount == '0) begin
                        state_d  = DONE;
                        result_d = bus.data_in;
                    end else begin
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                work_d = step_work;
                rem_d  = step_rem;
                if (step_rem == '0) begin
                    state_d  = DONE;
                    result_d = step_work;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Outputs are registered from the next state so they align with the state register.
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            work_q   <= '0;
            rem_q    <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            rem_q    <= rem_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer: expected results queued at accept, checked when done pulses.
module tb_shift_sequencer;

    typedef struct {
        logic [15:0] result;
        int          done_cyc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_vectors;
    int   n_miscompares;
    exp_t exp_q[$];

    shift_sequencer_if bus ();

    shift_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check_output(input string name, input logic [15:0] actual, input logic [15:0] expected);
        n_vectors++;
        if (actual !== expected) begin
            n_miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Scoreboard monitor: every done pulse must match the oldest queued expectation, on time.
    always @(negedge clk) begin
        if (rst_n && bus.done === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_vectors++;
                n_miscompares++;
                $display("[TB] FAIL unexpected_done: got done=1 at cycle %0d, expected none", cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check_output("result", bus.result, e.result);
                check_output("done_latency", 16'(cyc), 16'(e.done_cyc));
            end
        end
    end

    task automatic apply_stimulus(input logic [15:0] data, input logic [3:0] amt,
                                  input logic [15:0] exp_res, input int k, output int e0);
        exp_t e;
        @(negedge clk);
        bus.start   = 1'b1;
        bus.data_in = data;
        bus.amount  = amt;
        @(posedge clk);
        #1;
        e0          = cyc;
        e.result    = exp_res;
        e.done_cyc  = e0 + k;
        exp_q.push_back(e);
        bus.start   = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_vectors++;
            n_miscompares++;
            $display("[TB] FAIL drain_timeout: got %0d pending results, expected 0", exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        int   e0;
        exp_t e;
        n_vectors     = 0;
        n_miscompares = 0;
        bus.start     = 1'b0;
        bus.data_in   = '0;
        bus.amount    = '0;
        rst_n         = 1'b0;
        repeat (3) @(negedge clk);
        check_output("reset_busy",   16'(bus.busy),   16'h0000);
        check_output("reset_done",   16'(bus.done),   16'h0000);
        check_output("reset_result", bus.result,      16'h0000);
        rst_n = 1'b1;

        // Zero shift: done straight after accept, busy for a single cycle.
        apply_stimulus(16'h0001, 4'd0, 16'h0001, 0, e0);
        check_output("amt0_busy_during", 16'(bus.busy), 16'h0001);
        @(posedge clk); #1;
        check_output("amt0_busy_after", 16'(bus.busy), 16'h0000);
        wait_drain();

        apply_stimulus(16'h1234, 4'd7, 16'h1A00, 2, e0);
        wait_drain();
        check_output("result_hold_idle", bus.result, 16'h1A00);

        apply_stimulus(16'h0001, 4'd15, 16'h8000, 5, e0);
        check_output("shift_busy", 16'(bus.busy), 16'h0001);
        check_output("result_hold_shift", bus.result, 16'h1A00);
        wait_drain();

        // Start held high: the second accept lands on the edge after the IDLE cycle following done.
        apply_stimulus(16'hABCD, 4'd12, 16'hD000, 2, e0);
        bus.start   = 1'b1;
        bus.data_in = 16'h0003;
        bus.amount  = 4'd2;
        e.result    = 16'h000C;
        e.done_cyc  = e0 + 6;
        exp_q.push_back(e);
        while (cyc < e0 + 4) @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_drain();

        // A start pulse during SHIFT must be ignored.
        apply_stimulus(16'hFFFF, 4'd9, 16'hFE00, 4, e0);
        @(negedge clk);
        bus.start   = 1'b1;
        bus.data_in = 16'h0001;
        bus.amount  = 4'd3;
        @(negedge clk);
        bus.start   = 1'b0;
        wait_drain();

        // Reset mid-operation aborts without a done pulse.
        apply_stimulus(16'h5555, 4'd15, 16'h0000, 5, e0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check_output("abort_busy",   16'(bus.busy), 16'h0000);
        check_output("abort_done",   16'(bus.done), 16'h0000);
        check_output("abort_result", bus.result,    16'h0000);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);

        apply_stimulus(16'h5678, 4'd1, 16'hACF0, 1, e0);
        wait_drain();
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
